sw_debounce: RTL
================

# sw_debounce

Input conditioner for the board slide switches and push-buttons. It sits between the raw `sw*` pads and any logic that consumes them, including the switch-to-LED path. For each channel it synchronises the asynchronous pad into the `clk` domain, filters mechanical bounce, and produces:
- a clean level,
- single-cycle rise and fall pulses,
- a toggle bit flipped on every debounced press.

## Interface
- `N_SW`, 4: number of independent switch channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Legal range: ≥ 2.
- `CNT_W`, 20: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sw_raw`  in  N_SW  unsynchronised pad inputs; bit i = channel i.
- `sw_level`  out  N_SW  debounced level.
- `sw_rise`  out  N_SW  one-cycle pulse when `sw_level` goes 0→1.
- `sw_fall`  out  N_SW  one-cycle pulse when `sw_level` goes 1→0.
- `sw_toggle`  out  N_SW  flips on each `sw_rise`; for latching LEDs.

## Operation
- Channels are fully independent; each channel has its own synchroniser, counter and FSM.
- Synchroniser: two flops, `s1 <= sw_raw[i]` and `s2 <= s1`. Only `s2` feeds the filter.
- FSM states per channel:
  - STABLE_LO (level 0)
  - CONFIRM_HI (level 0, counting)
  - STABLE_HI (level 1)
  - CONFIRM_LO (level 1, counting)
- STABLE_x: if `s2` differs from level → go to CONFIRM_x' with `cnt <= 1`; otherwise stay, `cnt <= 0`.
- CONFIRM_x: if `s2` returns to the current level → go back to STABLE_x, `cnt <= 0`, no pulse.
- CONFIRM_x, `cnt == DEBOUNCE_CYCLES-1` and `s2` still differs → move to the new STABLE state, update level, `cnt <= 0`, pulse `sw_rise` or `sw_fall` in the following cycle.
- CONFIRM_x, otherwise → `cnt <= cnt + 1`.
- The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- Any bounce shorter than DEBOUNCE_CYCLES cycles, as seen at `s2`, is fully rejected.
- `sw_toggle[i]` inverts on the same edge that sets `sw_rise[i]`. `sw_fall` has no effect on it.
- Simultaneous events on different channels are allowed. Any combination of pulse bits may be high in the same cycle.
- `sw_rise[i]` and `sw_fall[i]` are never both high.

## Timing
- Reset values (async on `rst_n` low): `s1`, `s2`, `cnt` = 0; state = STABLE_LO; `sw_level`, `sw_rise`, `sw_fall`, `sw_toggle` = 0.
- Latency: let edge 0 be the first rising `clk` edge that samples a new, stable `sw_raw` value.
  - `sw_level` updates on edge DEBOUNCE_CYCLES+1.
  - The matching pulse is high for exactly the one cycle following that edge.
- All outputs are registered. There is no combinational path from `sw_raw`.
- Switch already high when reset is released: the channel sees it as a rise. `sw_level` rises on edge DEBOUNCE_CYCLES+1 after release, with `sw_rise` and a toggle.
- Reset asserted mid-count: the count is abandoned immediately and all state returns to reset values. No pulse is emitted.
- Minimum spacing between two accepted transitions on one channel: DEBOUNCE_CYCLES+1 cycles.

## Structure
- Shared package `board_io_pkg`:
  - the 2-bit state enum with the four states above;
  - the default debounce constant, `DEBOUNCE_10MS_50MHZ = 500000`.
- One sub-module, `sw_debounce_ch`: one channel covering synchroniser, counter, FSM and pulse/toggle registers.
- The top instantiates N_SW copies with a generate loop.
- Top-level elaboration check: DEBOUNCE_CYCLES ≥ 2 and DEBOUNCE_CYCLES < 2^CNT_W.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 8, CNT_W = 4, N_SW = 4.
- Clean press: `sw_raw[0]` 0→1 held → `sw_level[0]` = 1 on edge 9, `sw_rise[0]` high for exactly one cycle, `sw_toggle[0]` = 1; other bits stay 0.
- Bounce rejection: `sw_raw[1]` toggles every 3 cycles for 40 cycles, then settles to 1 → no pulse during the bounce; a single `sw_rise[1]` 9 edges after the final settle.
- Release and toggle: press, release, press on channel 2 with 20-cycle holds → `sw_rise`/`sw_fall` sequence is rise, fall, rise; `sw_toggle[2]` reads 1, 1, 0 after each event.
- Simultaneous: all four `sw_raw` bits rise on the same edge → `sw_rise` = 4'b1111 in one cycle, `sw_level` = 4'hF.
- Reset mid-count: `rst_n` pulled low at count 5 → all outputs 0 at once. With `sw_raw` still high after release, `sw_rise` appears 9 edges after the first post-reset edge.
- Near-threshold glitch: `sw_raw[3]` high for exactly 7 cycles, then low → no `sw_rise[3]`; high for 8 cycles → `sw_rise[3]` fires, then `sw_fall[3]` 9 edges after the drop.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: the per-channel debounce state encoding and
// the default filter length used on the 50 MHz board clock.
package board_io_pkg;

  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } db_state_t;

  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: two-flop synchroniser, stability counter, debounce FSM
// and the registered level / rise / fall / toggle outputs.
module sw_debounce_ch
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1, s2;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_evt, fall_evt;

  // All flops live here so reset clears every piece of channel state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= STABLE_LO;
      cnt       <= '0;
      sw_level  <= 1'b0;
      sw_rise   <= 1'b0;
      sw_fall   <= 1'b0;
      sw_toggle <= 1'b0;
    end else begin
      s1        <= sw_raw;
      s2        <= s1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sw_rise   <= rise_evt;
      sw_fall   <= fall_evt;
      sw_toggle <= sw_toggle ^ rise_evt;
      if (rise_evt)
        sw_level <= 1'b1;
      else if (fall_evt)
        sw_level <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      STABLE_LO: begin
        if (s2) begin
          state_nxt = CONFIRM_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_HI: begin
        if (!s2)
          state_nxt = STABLE_LO;
        else if (cnt == CNT_LAST)
          state_nxt = STABLE_HI;
        else
          cnt_nxt = cnt + CNT_ONE;
      end
      STABLE_HI: begin
        if (!s2) begin
          state_nxt = CONFIRM_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_LO: begin
        if (s2)
          state_nxt = STABLE_HI;
        else if (cnt == CNT_LAST)
          state_nxt = STABLE_LO;
        else
          cnt_nxt = cnt + CNT_ONE;
      end
      default: state_nxt = STABLE_LO;
    endcase
  end

  // Acceptance events; registered above so the pulse lands one cycle after the decision edge.
  always_comb begin
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    if (state == CONFIRM_HI && s2 && cnt == CNT_LAST)
      rise_evt = 1'b1;
    if (state == CONFIRM_LO && !s2 && cnt == CNT_LAST)
      fall_evt = 1'b1;
  end

endmodule

// File: rtl/sw_debounce.sv
// Input conditioner for the board switches: N_SW independent debounce
// channels, each producing a clean level, edge pulses and a press toggle.
module sw_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned N_SW            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int unsigned CNT_W           = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] sw_toggle
);

  // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping.
  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2 and < 2**CNT_W");
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw[i]),
      .sw_level (sw_level[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .sw_toggle(sw_toggle[i])
    );
  end

endmodule
